// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// Module   : ps2_rx_fifo
// Brief    : PS/2 keyboard receiver (sync, glitch filter, frame FSM) feeding a
//            keycode FIFO popped by a custom-instruction stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       read,
  output logic [7:0] keycode,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int c_addr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w   = c_addr_w + 1;
  localparam int c_filt_w  = $clog2(FILTER_LEN + 1);
  localparam int c_to_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_filt_w-1:0] c_filt_max = c_filt_w'(FILTER_LEN - 1);
  localparam logic [c_to_w-1:0]   c_to_max   = c_to_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic                r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [c_filt_w-1:0] r_filt_cnt;
  logic                r_filt_clk, r_filt_prev;
  logic                w_bit_evt;

  state_t              r_state;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_parity;
  logic [c_to_w-1:0]   r_to_cnt;
  logic                r_push;
  logic [7:0]          r_push_data;
  logic                r_frame_err;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_overflow;
  logic                w_empty, w_full, w_do_push, w_do_pop;

  // Synchronizers and filter idle high, matching an undriven PS/2 bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_filt_cnt  <= '0;
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_dat;
      r_dat_s2    <= r_dat_s1;
      r_filt_prev <= r_filt_clk;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_filt_max) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_bit_evt = r_filt_prev & ~r_filt_clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_to_cnt    <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state == S_IDLE || w_bit_evt) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      // A stalled partial frame is dropped silently
      if (r_state != S_IDLE && !w_bit_evt && r_to_cnt == c_to_max) begin
        r_state  <= S_IDLE;
        r_to_cnt <= '0;
      end else if (w_bit_evt) begin
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (r_dat_s2 && (^{r_shift, r_parity})) begin
              // Zero reads as "no key" downstream, so it is never queued
              r_push      <= (r_shift != 8'h00);
              r_push_data <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_depth);
  assign w_do_pop  = read & ~w_empty;
  assign w_do_push = r_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= r_push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_push && !w_do_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign keycode   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Brief    : Directed, table-driven bench for ps2_rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       read = 1'b0;
  logic [7:0] keycode;
  logic       empty, full, overflow, frame_err;

  int checks = 0;
  int errors = 0;
  int ferr_pulses = 0;
  int ferr_badw = 0;
  int ferr_run = 0;
  int exp_ferr = 0;

  ps2_rx_fifo #(.FIFO_DEPTH(16), .FILTER_LEN(8), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .read(read),
    .keycode(keycode), .empty(empty), .full(full), .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Count frame_err pulses and flag any pulse not exactly one cycle wide
  always @(negedge clk) begin
    if (frame_err) begin
      ferr_run++;
    end else if (ferr_run != 0) begin
      ferr_pulses++;
      if (ferr_run != 1) ferr_badw++;
      ferr_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    idle(10);
    ps2_clk = 1'b0;
    idle(20);
    ps2_clk = 1'b1;
    idle(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_dat = 1'b1;
    idle(30);
  endtask

  task automatic pop();
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  typedef struct {
    bit         op_pop;
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_kc;
    bit         exp_empty;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b0, 8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0, 0};
    vecs[1] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 0};
    vecs[2] = '{1'b0, 8'hF0, 1'b0, 1'b0, 8'hF0, 1'b0, 0};
    vecs[3] = '{1'b0, 8'h1C, 1'b0, 1'b0, 8'hF0, 1'b0, 0};
    vecs[4] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h1C, 1'b0, 0};
    vecs[5] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 0};
    vecs[6] = '{1'b0, 8'h1C, 1'b1, 1'b0, 8'h00, 1'b1, 1};
    vecs[7] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1};
    vecs[9] = '{1'b0, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 2};

    idle(3);
    check("rst_keycode", keycode, 8'h00);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    idle(5);
    check("post_rst_empty", empty, 1);
    check("post_rst_keycode", keycode, 8'h00);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].op_pop) pop();
      else send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
      idle(2);
      check($sformatf("vec%0d_keycode", i), keycode, vecs[i].exp_kc);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
      check($sformatf("vec%0d_full", i), full, 0);
      check($sformatf("vec%0d_ferr", i), ferr_pulses, vecs[i].exp_ferr);
    end
    exp_ferr = 2;

    // Short low glitch with data low must not start a frame
    @(negedge clk);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    idle(2);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    idle(20);
    send_frame(8'h33, 1'b0, 1'b0);
    check("glitch_keycode", keycode, 8'h33);
    check("glitch_ferr", ferr_pulses, exp_ferr);
    pop();
    idle(1);
    check("glitch_pop_empty", empty, 1);

    // Partial frame then stall beyond the timeout
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    idle(1500);
    send_frame(8'h2A, 1'b0, 1'b0);
    check("timeout_keycode", keycode, 8'h2A);
    check("timeout_ferr", ferr_pulses, exp_ferr);
    pop();
    idle(1);
    check("timeout_empty", empty, 1);

    // Fill, overflow, then drain in order
    for (int i = 1; i <= 17; i++) begin
      send_frame(8'(i), 1'b0, 1'b0);
      if (i == 15) check("fill15_full", full, 0);
      if (i == 16) begin
        check("fill16_full", full, 1);
        check("fill16_overflow", overflow, 0);
      end
    end
    check("fill17_overflow", overflow, 1);
    check("fill17_full", full, 1);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain%0d_keycode", i), keycode, 32'(i));
      pop();
    end
    idle(1);
    check("drain_empty", empty, 1);
    check("drain_keycode", keycode, 8'h00);
    check("drain_overflow_sticky", overflow, 1);
    pop();
    idle(1);
    check("read_empty_keycode", keycode, 8'h00);
    check("read_empty_empty", empty, 1);

    // Reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    check("midrst_overflow", overflow, 0);
    check("midrst_empty", empty, 1);
    check("midrst_keycode", keycode, 8'h00);
    reset = 1'b1;
    ps2_dat = 1'b1;
    idle(30);
    check("midrst_no_push", empty, 1);
    send_frame(8'h44, 1'b0, 1'b0);
    check("midrst_keycode_44", keycode, 8'h44);
    pop();
    idle(1);
    check("midrst_final_empty", empty, 1);

    check("ferr_width", ferr_badw, 0);
    check("ferr_total", ferr_pulses, exp_ferr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
